acc_alu_seq: RTL and testbench
==============================

// Module: acc_alu_seq
// PURPOSE
//  Execute stage feeding the register file write port. Consumes the accumulator
//  (R0) and one operand register read combinationally from the register file.
//  Produces the 8-bit write-back value, the status flag and the write enable.
//  Single-cycle ops finish in 1 cycle; shifts and multiply iterate one bit per cycle.
//  A start/busy/done handshake stalls the controller.
// PARAMETERS
//  DW   8  datapath width; power of 2; shift amount uses low $clog2(DW) operand bits
//  OPW  4  opcode width
// PORTS
//  clk       in   1    clock; all state updates on posedge
//  reset     in   1    synchronous, active-high reset
//  start     in   1    launch op; sampled only in IDLE
//  op        in   OPW  0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 CMP,7 SHL,8 SHR,9 MUL,10 ADC; 11-15=NOP
//  acc_in    in   DW   R0 value from register file
//  opnd_in   in   DW   operand register value from register file
//  flag_in   in   1    current status flag (carry-in for ADC)
//  busy      out  1    high while a multi-cycle op iterates
//  done      out  1    1-cycle pulse: result/flag_out/wr_en valid this cycle
//  result    out  DW   write-back data (register file dat_in)
//  flag_out  out  1    new status flag (register file flag)
//  wr_en     out  1    equals done & (op != NOP); drives register file wr_en
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, wr_en=0, result=0, flag_out=0, count=0.
//  - FSM: IDLE -> (start & single-cycle op) DONE; IDLE -> (start & iter op, k>0) EXEC;
//    EXEC -> DONE when count reaches 0; DONE -> IDLE unconditionally.
//  - Latching: op, acc_in, opnd_in, flag_in are captured on the start edge.
//    Later input changes do not affect the running op.
//  - Latency: start at edge E0 -> done high for the cycle after E0+L.
//    L=0 for NOP/ADD/SUB/AND/OR/XOR/CMP/ADC, and for SHL/SHR with k=0.
//    L=k for SHL/SHR, where k=opnd_in[$clog2(DW)-1:0].
//    L=DW for MUL (one shift-add per EXEC cycle).
//  - Throughput: start is ignored in EXEC and DONE; back-to-back start is accepted in
//    the cycle after done.
//  - Arithmetic is modulo 2^DW.
//    ADD: result=a+b, flag=carry out. ADC: result=a+b+flag_in, flag=carry out.
//    SUB: result=a-b, flag=borrow (a<b unsigned).
//    AND/OR/XOR: flag=(result==0).
//    CMP: result=a unchanged, flag=(a==b).
//    SHL/SHR: logical, zero fill; flag=last bit shifted out; k=0 -> result=a, flag=0.
//    MUL: result=low DW bits of a*b; flag=(high DW bits != 0).
//  - NOP: done pulses after 1 cycle; wr_en=0; result and flag_out hold previous values.
//  - result/flag_out hold their value after done until the next op completes.
//  - busy=1 exactly in EXEC; done and busy are never high together.
//  - Reset mid-op (EXEC or DONE) aborts the op: no done/wr_en pulse, all outputs take
//    their reset values the next cycle.
//  - start and reset in the same cycle: reset wins.
// CONFIGURATION
//  ACC_ALU_MUL_EN defined: op 9 is an iterative shift-add multiply as above.
//  ACC_ALU_MUL_EN undefined:
//    - op 9 decodes as NOP (1-cycle done, wr_en=0) and no multiplier state is built.
//    - busy occurs only for shifts.
// TESTING
//  1. Reset held 2 cycles with start=1, op=ADD -> busy=0, done=0, wr_en=0, result=0.
//  2. ADD a=0xF0, b=0x20 -> 1 cycle later done=1, wr_en=1, result=0x10, flag=1.
//     SUB a=0x05, b=0x07 -> result=0xFE, flag=1.
//  3. SHL a=0x81, b=0x03 -> busy 3 cycles, then done, result=0x08, flag=0.
//     SHR a=0x81, b=0x00 -> 1-cycle done, result=0x81, flag=0.
//  4. MUL (ACC_ALU_MUL_EN) a=0x12, b=0x10 -> busy 8 cycles, result=0x20, flag=1.
//     Macro off -> 1-cycle done, wr_en=0.
//  5. start pulsed during EXEC with op=ADD -> ignored, in-flight SHL result intact.
//     reset asserted mid-EXEC -> no done pulse, outputs zero next cycle.
//  6. ADC a=0xFF, b=0x00, flag_in=1 -> result=0x00, flag=1.
//     CMP a=b=0x3C -> result=0x3C, flag=1, wr_en=1.

Source files
------------

// File: rtl/acc_alu_seq.sv
// Execute stage: accumulator ALU with single-cycle ops and bit-serial shifts/multiply.
// Optional build macro ACC_ALU_MUL_EN enables the iterative shift-add multiply (op 9).
module acc_alu_seq #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  acc_in,
  input  logic [DW-1:0]  opnd_in,
  input  logic           flag_in,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           flag_out,
  output logic           wr_en
);
  localparam int unsigned SW = $clog2(DW);
  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [OPW-1:0] OpAdd = OPW'(1);
  localparam logic [OPW-1:0] OpSub = OPW'(2);
  localparam logic [OPW-1:0] OpAnd = OPW'(3);
  localparam logic [OPW-1:0] OpOr  = OPW'(4);
  localparam logic [OPW-1:0] OpXor = OPW'(5);
  localparam logic [OPW-1:0] OpCmp = OPW'(6);
  localparam logic [OPW-1:0] OpShl = OPW'(7);
  localparam logic [OPW-1:0] OpShr = OPW'(8);
  localparam logic [OPW-1:0] OpMul = OPW'(9);
  localparam logic [OPW-1:0] OpAdc = OPW'(10);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e         state_q;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  work_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q, wr_en_q, flag_q;
  logic [DW-1:0]  result_q;
`ifdef ACC_ALU_MUL_EN
  logic [DW-1:0]   mcand_q;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [DW:0]     psum;
`endif

  logic [DW:0]   add_w, adc_w, sub_w;
  logic [SW-1:0] k_w;
  logic [DW-1:0] sc_res;
  logic          sc_flag, sc_wr, sc_iter;
  logic [CW-1:0] sc_cnt;

  assign add_w = {1'b0, acc_in} + {1'b0, opnd_in};
  assign adc_w = add_w + {{DW{1'b0}}, flag_in};
  assign sub_w = {1'b0, acc_in} - {1'b0, opnd_in};
  assign k_w   = opnd_in[SW-1:0];

  // Decode at the start edge; NOP keeps the previous result/flag.
  always_comb begin
    sc_res  = result_q;
    sc_flag = flag_q;
    sc_wr   = 1'b1;
    sc_iter = 1'b0;
    sc_cnt  = CW'(k_w);
    case (op)
      OpAdd: begin sc_res = add_w[DW-1:0]; sc_flag = add_w[DW]; end
      OpAdc: begin sc_res = adc_w[DW-1:0]; sc_flag = adc_w[DW]; end
      OpSub: begin sc_res = sub_w[DW-1:0]; sc_flag = sub_w[DW]; end
      OpAnd: begin sc_res = acc_in & opnd_in; sc_flag = ~|(acc_in & opnd_in); end
      OpOr:  begin sc_res = acc_in | opnd_in; sc_flag = ~|(acc_in | opnd_in); end
      OpXor: begin sc_res = acc_in ^ opnd_in; sc_flag = ~|(acc_in ^ opnd_in); end
      OpCmp: begin sc_res = acc_in; sc_flag = (acc_in == opnd_in); end
      OpShl, OpShr: begin
        if (k_w == '0) begin
          sc_res  = acc_in;
          sc_flag = 1'b0;
        end else begin
          sc_iter = 1'b1;
        end
      end
`ifdef ACC_ALU_MUL_EN
      OpMul: begin sc_iter = 1'b1; sc_cnt = CW'(DW); end
`endif
      default: sc_wr = 1'b0;
    endcase
  end

  logic [DW-1:0] step_work, fin_res;
  logic          fin_flag;

  // One iteration step; fin_* is the value committed on the last step.
  always_comb begin
    if (op_q == OpShl) begin
      step_work = {work_q[DW-2:0], 1'b0};
      fin_flag  = work_q[DW-1];
    end else begin
      step_work = {1'b0, work_q[DW-1:1]};
      fin_flag  = work_q[0];
    end
    fin_res = step_work;
`ifdef ACC_ALU_MUL_EN
    psum   = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {psum, prod_q[DW-1:1]};
    if (op_q == OpMul) begin
      fin_res  = prod_d[DW-1:0];
      fin_flag = |prod_d[2*DW-1:DW];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      flag_q   <= 1'b0;
      result_q <= '0;
`ifdef ACC_ALU_MUL_EN
      mcand_q  <= '0;
      prod_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            work_q <= acc_in;
            cnt_q  <= sc_cnt;
`ifdef ACC_ALU_MUL_EN
            mcand_q <= opnd_in;
            prod_q  <= {{DW{1'b0}}, acc_in};
`endif
            if (sc_iter) begin
              state_q <= StExec;
              busy_q  <= 1'b1;
            end else begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              wr_en_q  <= sc_wr;
              result_q <= sc_res;
              flag_q   <= sc_flag;
            end
          end
        end
        StExec: begin
          work_q <= step_work;
          cnt_q  <= cnt_q - CW'(1);
`ifdef ACC_ALU_MUL_EN
          prod_q <= prod_d;
`endif
          if (cnt_q == CW'(1)) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            wr_en_q  <= 1'b1;
            result_q <= fin_res;
            flag_q   <= fin_flag;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign result   = result_q;
  assign flag_out = flag_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq: directed cases plus random ops vs. an arithmetic model.
module tb_acc_alu_seq;
  logic       clk = 1'b0;
  logic       reset, start, flag_in;
  logic [3:0] op;
  logic [7:0] acc_in, opnd_in;
  logic       busy, done, flag_out, wr_en;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  int exp_res = 0;
  int exp_flag = 0;

`ifdef ACC_ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  acc_alu_seq #(.DW(8), .OPW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .acc_in   (acc_in),
    .opnd_in  (opnd_in),
    .flag_in  (flag_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag_out (flag_out),
    .wr_en    (wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Expected result/flag/write-enable/latency from the arithmetic definition of each op.
  task automatic model(input int o, input int a, input int b, input int f,
                       output int res, output int flg, output int wr, output int lat);
    int k, s, p;
    k   = b % 8;
    res = exp_res;
    flg = exp_flag;
    wr  = 1;
    lat = 0;
    case (o)
      1:  begin s = a + b;     res = s % 256; flg = (s > 255) ? 1 : 0; end
      10: begin s = a + b + f; res = s % 256; flg = (s > 255) ? 1 : 0; end
      2:  begin res = (a - b + 256) % 256; flg = (a < b) ? 1 : 0; end
      3:  begin res = a & b; flg = (res == 0) ? 1 : 0; end
      4:  begin res = a | b; flg = (res == 0) ? 1 : 0; end
      5:  begin res = a ^ b; flg = (res == 0) ? 1 : 0; end
      6:  begin res = a; flg = (a == b) ? 1 : 0; end
      7: begin
        if (k == 0) begin res = a; flg = 0; end
        else begin res = (a << k) % 256; flg = (a >> (8 - k)) & 1; lat = k; end
      end
      8: begin
        if (k == 0) begin res = a; flg = 0; end
        else begin res = a >> k; flg = (a >> (k - 1)) & 1; lat = k; end
      end
      9: begin
        if (MulEn) begin p = a * b; res = p % 256; flg = (p > 255) ? 1 : 0; lat = 8; end
        else wr = 0;
      end
      default: wr = 0;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic run_op(input int o, input int a, input int b, input int f, input bit poke);
    int res, flg, wr, lat, n;
    bit seen;
    model(o, a, b, f, res, flg, wr, lat);
    start   = 1'b1;
    op      = 4'(o);
    acc_in  = 8'(a);
    opnd_in = 8'(b);
    flag_in = 1'(f);
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 4'($urandom_range(0, 15));
    acc_in  = 8'($urandom_range(0, 255));
    opnd_in = 8'($urandom_range(0, 255));
    flag_in = 1'($urandom_range(0, 1));
    seen = 1'b0;
    for (n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("busy_exec", busy, 1);
      if (poke) begin
        start = 1'b1;
        op    = 4'd1;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", n, lat);
    chk("busy_at_done", busy, 0);
    chk("wr_en", wr_en, wr);
    chk("result", result, res);
    chk("flag", flag_out, flg);
    exp_res  = res;
    exp_flag = flg;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("wr_pulse", wr_en, 0);
    chk("result_hold", result, exp_res);
    chk("flag_hold", flag_out, exp_flag);
  endtask

  initial begin
    bit late_done;
    reset   = 1'b1;
    start   = 1'b1;
    op      = 4'd1;
    acc_in  = 8'hF0;
    opnd_in = 8'h20;
    flag_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_result", result, 0);
    chk("rst_flag", flag_out, 0);
    reset = 1'b0;
    start = 1'b0;

    run_op(1, 8'hF0, 8'h20, 0, 1'b0);
    run_op(2, 8'h05, 8'h07, 0, 1'b0);
    run_op(7, 8'h81, 8'h03, 0, 1'b1);
    run_op(8, 8'h81, 8'h00, 0, 1'b0);
    run_op(9, 8'h12, 8'h10, 0, 1'b0);
    run_op(10, 8'hFF, 8'h00, 1, 1'b0);
    run_op(6, 8'h3C, 8'h3C, 0, 1'b0);
    run_op(0, 8'h11, 8'h22, 1, 1'b0);
    run_op(12, 8'h11, 8'h22, 1, 1'b0);
    run_op(3, 8'h0F, 8'hF0, 0, 1'b0);
    run_op(8, 8'h81, 8'h01, 0, 1'b0);
    run_op(7, 8'hA5, 8'h08, 0, 1'b0);

    // Reset in the middle of a long shift.
    start   = 1'b1;
    op      = 4'd7;
    acc_in  = 8'h55;
    opnd_in = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wr", wr_en, 0);
    chk("abort_result", result, 0);
    chk("abort_flag", flag_out, 0);
    reset     = 1'b0;
    exp_res   = 0;
    exp_flag  = 0;
    late_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) late_done = 1'b1;
    end
    chk("abort_quiet", late_done, 0);

    repeat (60) begin
      run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
